// File: rtl/read_arbiter.sv
// read_arbiter -- grants the shared read channel to one of three masters.
//
// The grant is held until the owner's burst completes (rd_state_refre) or
// the hold counter expires. After every release there is at least one idle
// cycle before the next grant.
//
// Request/grant semantics: a master requests by holding rd_req_x high. It
// owns the channel for as long as rd_grant shows its bit. Request changes
// during a grant, including the owner dropping its request, do not affect
// the grant. rd_state_refre is only honoured while a grant is active.
//
// Configuration macro: RD_ARB_ROUND_ROBIN_EN
//   defined   -> rotating priority, starting at last_id+1 (mod 3)
//   undefined -> fixed priority 0 > 1 > 2
//
// Parameters:
//   TIMEOUT_CYCLES  maximum number of GRANT cycles without burst completion (2..65535)
//
// Ports:
//   sys_clk         clock; all state changes on its rising edge
//   sys_rstn        asynchronous active-low reset
//   rd_req_0/1/2    per-master read requests
//   rd_state_refre  one-cycle pulse: last read beat of the burst was accepted
//   rd_grant        one-hot owner of the channel (000 = no owner)
//   rd_grant_id     binary owner index, valid while rd_busy=1
//   rd_busy         high while a grant is active
//   rd_timeout      one-cycle pulse when a grant is forcibly released
//   dbg_state_o     current FSM state (0 = IDLE, 1 = GRANT)
module read_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       sys_clk,
    input  logic       sys_rstn,
    input  logic       rd_req_0,
    input  logic       rd_req_1,
    input  logic       rd_req_2,
    input  logic       rd_state_refre,
    output logic [2:0] rd_grant,
    output logic [1:0] rd_grant_id,
    output logic       rd_busy,
    output logic       rd_timeout,
    output logic       dbg_state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Counter value on the last allowed GRANT cycle.
    localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]  last_id_q, last_id_d;

    logic [2:0]  req;
    logic [1:0]  pick_id;

    assign req = {rd_req_2, rd_req_1, rd_req_0};

    // Selection of the winning requester. Only meaningful when |req.
    always_comb begin
        pick_id = 2'd0;
`ifdef RD_ARB_ROUND_ROBIN_EN
        // Search begins one past the last owner and wraps around.
        case (last_id_q)
            2'd0: begin
                if (req[1])      pick_id = 2'd1;
                else if (req[2]) pick_id = 2'd2;
                else             pick_id = 2'd0;
            end
            2'd1: begin
                if (req[2])      pick_id = 2'd2;
                else if (req[0]) pick_id = 2'd0;
                else             pick_id = 2'd1;
            end
            default: begin
                if (req[0])      pick_id = 2'd0;
                else if (req[1]) pick_id = 2'd1;
                else             pick_id = 2'd2;
            end
        endcase
`else
        if (req[0])      pick_id = 2'd0;
        else if (req[1]) pick_id = 2'd1;
        else             pick_id = 2'd2;
`endif
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        last_id_d  = last_id_q;

        case (state_q)
            IDLE: begin
                grant_d    = 3'b000;
                grant_id_d = 2'd0;
                busy_d     = 1'b0;
                if (|req) begin
                    state_d    = GRANT;
                    grant_d    = 3'b001 << pick_id;
                    grant_id_d = pick_id;
                    busy_d     = 1'b1;
                    hold_cnt_d = 16'd0;
                    last_id_d  = pick_id;
                end
            end
            GRANT: begin
                // Burst completion takes precedence over an expiring counter,
                // so a release on the last allowed cycle is not a timeout.
                if (rd_state_refre) begin
                    state_d    = IDLE;
                    grant_d    = 3'b000;
                    grant_id_d = 2'd0;
                    busy_d     = 1'b0;
                    hold_cnt_d = 16'd0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = IDLE;
                    grant_d    = 3'b000;
                    grant_id_d = 2'd0;
                    busy_d     = 1'b0;
                    timeout_d  = 1'b1;
                    hold_cnt_d = 16'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= IDLE;
            grant_q    <= 3'b000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= 16'd0;
            // Master 2 counts as the previous owner, so master 0 goes first.
            last_id_q  <= 2'd2;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_id_q  <= last_id_d;
        end
    end

    assign rd_grant    = grant_q;
    assign rd_grant_id = grant_id_q;
    assign rd_busy     = busy_q;
    assign rd_timeout  = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_read_arbiter.sv
module tb_read_arbiter;

  localparam int T = 8;

  logic       sys_clk;
  logic       sys_rstn;
  logic       rd_req_0, rd_req_1, rd_req_2;
  logic       rd_state_refre;
  logic [2:0] rd_grant;
  logic [1:0] rd_grant_id;
  logic       rd_busy;
  logic       rd_timeout;
  logic       dbg_state_o;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  read_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .sys_clk(sys_clk),
    .sys_rstn(sys_rstn),
    .rd_req_0(rd_req_0),
    .rd_req_1(rd_req_1),
    .rd_req_2(rd_req_2),
    .rd_state_refre(rd_state_refre),
    .rd_grant(rd_grant),
    .rd_grant_id(rd_grant_id),
    .rd_busy(rd_busy),
    .rd_timeout(rd_timeout),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] r);
    {rd_req_2, rd_req_1, rd_req_0} = r;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_to);
    check({tag, "_grant"}, 16'(rd_grant), 16'h0);
    check({tag, "_busy"}, 16'(rd_busy), 16'h0);
    check({tag, "_timeout"}, 16'(rd_timeout), 16'(exp_to));
  endtask

  function automatic logic [1:0] id_of(input logic [2:0] g);
    case (g)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // scoreboard: wait (bounded) for the next grant, pop and compare
  task automatic wait_grant(input string tag);
    int n;
    logic [2:0] e;
    n = 0;
    while (rd_busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 16'(n), 16'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_grant"}, 16'(rd_grant), 16'(e));
      check({tag, "_id"}, 16'(rd_grant_id), 16'(id_of(e)));
      check({tag, "_state"}, 16'(dbg_state_o), 16'd1);
    end
  endtask

  task automatic do_reset();
    #2;
    sys_rstn = 1'b0;
    #1;
    check_idle("reset", 1'b0);
    check("reset_id", 16'(rd_grant_id), 16'h0);
    check("reset_state", 16'(dbg_state_o), 16'h0);
    tick();
    #2;
    sys_rstn = 1'b1;
    tick();
  endtask

  logic [2:0] rr_seq [4];

  initial begin
    sys_rstn = 1'b1;
    set_req(3'b000);
    rd_state_refre = 1'b0;
    tick();
    do_reset();

    // single requester, burst completion after a few cycles
    set_req(3'b010);
    exp_q.push_back(3'b010);
    wait_grant("req1");
    set_req(3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("req1_hold", 16'(rd_grant), 16'(3'b010));
    end
    rd_state_refre = 1'b1;
    tick();
    rd_state_refre = 1'b0;
    check_idle("req1_release", 1'b0);

    // completion pulse while idle is ignored
    rd_state_refre = 1'b1;
    tick();
    rd_state_refre = 1'b0;
    check_idle("idle_refre", 1'b0);
    tick();
    check_idle("idle_stay", 1'b0);

    // all masters requesting, completion every 4th grant cycle
    do_reset();
`ifdef RD_ARB_ROUND_ROBIN_EN
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    rr_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    set_req(3'b111);
    for (int g = 0; g < 4; g++) begin
      exp_q.push_back(rr_seq[g]);
      wait_grant("all");
      tick();
      tick();
      check("all_hold", 16'(rd_grant), 16'(rr_seq[g]));
      rd_state_refre = 1'b1;
      tick();
      rd_state_refre = 1'b0;
      check_idle("all_gap", 1'b0);
    end
    set_req(3'b000);
    tick();

    // timeout: exactly T cycles in GRANT, then a one-cycle timeout pulse
    do_reset();
    set_req(3'b100);
    exp_q.push_back(3'b100);
    wait_grant("to");
    set_req(3'b000);
    for (int i = 1; i < T; i++) begin
      tick();
      check("to_busy", 16'(rd_busy), 16'd1);
      check("to_nopulse", 16'(rd_timeout), 16'd0);
    end
    tick();
    check_idle("to_release", 1'b1);
    tick();
    check_idle("to_pulse_end", 1'b0);

    // completion on the last allowed cycle wins over the timeout
    set_req(3'b100);
    exp_q.push_back(3'b100);
    wait_grant("race");
    set_req(3'b000);
    for (int i = 1; i < T; i++) tick();
    check("race_busy", 16'(rd_busy), 16'd1);
    rd_state_refre = 1'b1;
    tick();
    rd_state_refre = 1'b0;
    check_idle("race_release", 1'b0);
    tick();
    check_idle("race_after", 1'b0);

    // asynchronous reset in the middle of a grant
    set_req(3'b100);
    exp_q.push_back(3'b100);
    wait_grant("mid");
    set_req(3'b111);
    tick();
    #2;
    sys_rstn = 1'b0;
    #1;
    check_idle("mid_reset", 1'b0);
    check("mid_reset_id", 16'(rd_grant_id), 16'h0);
    tick();
    #2;
    sys_rstn = 1'b1;
    exp_q.push_back(3'b001);
    wait_grant("post_reset");

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // bounded run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
